// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register: bubbles on hazard or branch flush, holds on freeze, replays a frozen flush.
// Define ID_EXE_PERF_EN to add saturating bubble/flush performance counters.
module id_exe_stage_reg #(
  parameter int DATA_W = 32
`ifdef ID_EXE_PERF_EN
  , parameter int PERF_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              hazard_detected,
  input  logic [DATA_W-1:0] id_pc,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic              id_mem_w_en,
  input  logic              id_b,
  input  logic              id_s,
  input  logic              id_imm,
  input  logic [3:0]        id_exe_cmd,
  input  logic [DATA_W-1:0] id_val_rn,
  input  logic [DATA_W-1:0] id_val_rm,
  input  logic [11:0]       id_shift_operand,
  input  logic [23:0]       id_signed_imm_24,
  input  logic [3:0]        id_dest,
  input  logic [3:0]        id_src1,
  input  logic [3:0]        id_src2,
  input  logic [3:0]        id_status,
  output logic [DATA_W-1:0] exe_pc,
  output logic              exe_wb_en,
  output logic              exe_mem_r_en,
  output logic              exe_mem_w_en,
  output logic              exe_b,
  output logic              exe_s,
  output logic              exe_imm,
  output logic [3:0]        exe_exe_cmd,
  output logic [DATA_W-1:0] exe_val_rn,
  output logic [DATA_W-1:0] exe_val_rm,
  output logic [11:0]       exe_shift_operand,
  output logic [23:0]       exe_signed_imm_24,
  output logic [3:0]        exe_dest,
  output logic [3:0]        exe_src1,
  output logic [3:0]        exe_src2,
  output logic [3:0]        exe_status,
`ifdef ID_EXE_PERF_EN
  output logic [PERF_W-1:0] bubble_cnt,
  output logic [PERF_W-1:0] flush_cnt,
`endif
  output logic              exe_valid
);

  localparam int BUNDLE_W = 3 * DATA_W + 62;

  logic [BUNDLE_W-1:0] id_bundle;
  logic [BUNDLE_W-1:0] exe_bundle;
  logic                flush_pend;
  logic                flush_now;
  logic                bubble;

  // All instruction fields travel as one vector so a bubble zeroes every field at once.
  assign id_bundle = {id_pc, id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm,
                      id_exe_cmd, id_val_rn, id_val_rm, id_shift_operand, id_signed_imm_24,
                      id_dest, id_src1, id_src2, id_status};

  assign {exe_pc, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s, exe_imm,
          exe_exe_cmd, exe_val_rn, exe_val_rm, exe_shift_operand, exe_signed_imm_24,
          exe_dest, exe_src1, exe_src2, exe_status} = exe_bundle;

  assign flush_now = flush | flush_pend;
  assign bubble    = flush_now | hazard_detected;

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_bundle <= '0;
      exe_valid  <= 1'b0;
    end else if (!freeze) begin
      if (bubble) begin
        exe_bundle <= '0;
        exe_valid  <= 1'b0;
      end else begin
        exe_bundle <= id_bundle;
        exe_valid  <= 1'b1;
      end
    end
  end

  // A flush seen while frozen is remembered and consumed on the first unfrozen edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pend <= 1'b0;
    end else if (freeze) begin
      if (flush) flush_pend <= 1'b1;
    end else begin
      flush_pend <= 1'b0;
    end
  end

`ifdef ID_EXE_PERF_EN
  // Flush bubbles are counted separately from pure hazard bubbles; both saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (!freeze) begin
      if (flush_now) begin
        if (flush_cnt != {PERF_W{1'b1}}) flush_cnt <= flush_cnt + 1'b1;
      end else if (hazard_detected) begin
        if (bubble_cnt != {PERF_W{1'b1}}) bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed self-checking bench for id_exe_stage_reg; counter checks run when ID_EXE_PERF_EN is defined.
module tb_id_exe_stage_reg;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst, freeze, flush, hazard_detected;
  logic [DATA_W-1:0] id_pc, id_val_rn, id_val_rm;
  logic              id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm;
  logic [3:0]        id_exe_cmd, id_dest, id_src1, id_src2, id_status;
  logic [11:0]       id_shift_operand;
  logic [23:0]       id_signed_imm_24;
  logic [DATA_W-1:0] exe_pc, exe_val_rn, exe_val_rm;
  logic              exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s, exe_imm, exe_valid;
  logic [3:0]        exe_exe_cmd, exe_dest, exe_src1, exe_src2, exe_status;
  logic [11:0]       exe_shift_operand;
  logic [23:0]       exe_signed_imm_24;
`ifdef ID_EXE_PERF_EN
  logic [3:0]        bubble_cnt, flush_cnt;
`endif

  int check_count = 0;
  int fail_count  = 0;

  always #5 clk = ~clk;

`ifdef ID_EXE_PERF_EN
  id_exe_stage_reg #(.DATA_W(DATA_W), .PERF_W(4)) dut (
`else
  id_exe_stage_reg #(.DATA_W(DATA_W)) dut (
`endif
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard_detected(hazard_detected),
    .id_pc(id_pc), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
    .id_b(id_b), .id_s(id_s), .id_imm(id_imm), .id_exe_cmd(id_exe_cmd),
    .id_val_rn(id_val_rn), .id_val_rm(id_val_rm), .id_shift_operand(id_shift_operand),
    .id_signed_imm_24(id_signed_imm_24), .id_dest(id_dest), .id_src1(id_src1),
    .id_src2(id_src2), .id_status(id_status),
    .exe_pc(exe_pc), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .exe_mem_w_en(exe_mem_w_en), .exe_b(exe_b), .exe_s(exe_s), .exe_imm(exe_imm),
    .exe_exe_cmd(exe_exe_cmd), .exe_val_rn(exe_val_rn), .exe_val_rm(exe_val_rm),
    .exe_shift_operand(exe_shift_operand), .exe_signed_imm_24(exe_signed_imm_24),
    .exe_dest(exe_dest), .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_status(exe_status),
`ifdef ID_EXE_PERF_EN
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
`endif
    .exe_valid(exe_valid)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the stall controls, take one rising edge and settle just after it.
  task automatic applyStimulus(input logic r, input logic frz, input logic fl, input logic hz);
    rst = r; freeze = frz; flush = fl; hazard_detected = hz;
    @(posedge clk);
    #1;
  endtask

  task automatic setInstr(input logic [31:0] pc, input logic [3:0] dest, input logic wb, input logic mr);
    id_pc = pc; id_dest = dest; id_wb_en = wb; id_mem_r_en = mr;
    id_mem_w_en = 1'b1; id_b = 1'b1; id_s = 1'b1; id_imm = 1'b1;
    id_exe_cmd = 4'h9; id_val_rn = pc ^ 32'hAAAA5555; id_val_rm = 32'h1234_5678;
    id_shift_operand = 12'hABC; id_signed_imm_24 = 24'h80_0001;
    id_src1 = 4'h1; id_src2 = 4'h2; id_status = 4'hA;
  endtask

  task automatic checkBubble(input string tag);
    checkOutput({tag, ".valid"}, 64'(exe_valid), 64'd0);
    checkOutput({tag, ".wb_en"}, 64'(exe_wb_en), 64'd0);
    checkOutput({tag, ".mem_r_en"}, 64'(exe_mem_r_en), 64'd0);
    checkOutput({tag, ".mem_w_en"}, 64'(exe_mem_w_en), 64'd0);
    checkOutput({tag, ".b"}, 64'(exe_b), 64'd0);
    checkOutput({tag, ".dest"}, 64'(exe_dest), 64'd0);
    checkOutput({tag, ".pc"}, 64'(exe_pc), 64'd0);
    checkOutput({tag, ".status"}, 64'(exe_status), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    setInstr(32'h0, 4'd5, 1'b1, 1'b0);

    // Reset held for two edges with a live ID instruction.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkBubble("reset");
      checkOutput("reset.flush_pend", 64'(dut.flush_pend), 64'd0);
    end

    // Normal load.
    setInstr(32'h10, 4'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("load.pc", 64'(exe_pc), 64'h10);
    checkOutput("load.dest", 64'(exe_dest), 64'd3);
    checkOutput("load.wb_en", 64'(exe_wb_en), 64'd1);
    checkOutput("load.valid", 64'(exe_valid), 64'd1);
    checkOutput("load.val_rn", 64'(exe_val_rn), 64'hAAAA5545);
    checkOutput("load.status", 64'(exe_status), 64'hA);
    checkOutput("load.imm24", 64'(exe_signed_imm_24), 64'h800001);
    checkOutput("load.cmd", 64'(exe_exe_cmd), 64'h9);

    // No combinational path: changing ID without an edge leaves EXE alone.
    id_pc = 32'hDEAD_BEEF;
    #2;
    checkOutput("nocomb.pc", 64'(exe_pc), 64'h10);

    // Hazard bubble, then the held ID instruction loads.
    setInstr(32'h20, 4'd7, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkBubble("hazard");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("after_hazard.valid", 64'(exe_valid), 64'd1);
    checkOutput("after_hazard.mem_r_en", 64'(exe_mem_r_en), 64'd1);
    checkOutput("after_hazard.dest", 64'(exe_dest), 64'd7);

    // Freeze for three edges with a flush in the second one.
    setInstr(32'h30, 4'd9, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, (i == 1), 1'b0);
      checkOutput("freeze.pc", 64'(exe_pc), 64'h20);
      checkOutput("freeze.valid", 64'(exe_valid), 64'd1);
    end
    checkOutput("freeze.flush_pend", 64'(dut.flush_pend), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkBubble("pend_flush");
    checkOutput("pend_flush.flush_pend", 64'(dut.flush_pend), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("after_pend.pc", 64'(exe_pc), 64'h30);
    checkOutput("after_pend.valid", 64'(exe_valid), 64'd1);

    // Flush and hazard together give one bubble counted as a flush.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    setInstr(32'h40, 4'd4, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkBubble("flush_haz");
`ifdef ID_EXE_PERF_EN
    checkOutput("flush_haz.flush_cnt", 64'(flush_cnt), 64'd1);
    checkOutput("flush_haz.bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("after_flush.valid", 64'(exe_valid), 64'd1);
    checkOutput("after_flush.pc", 64'(exe_pc), 64'h40);

    // Reset while frozen with a pending flush empties everything.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkBubble("rst_frozen");
    checkOutput("rst_frozen.flush_pend", 64'(dut.flush_pend), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_frozen.reload_valid", 64'(exe_valid), 64'd1);

`ifdef ID_EXE_PERF_EN
    // Hazard counter: hold under freeze, saturate at 0xF, clear on reset.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("perf.bubble5", 64'(bubble_cnt), 64'd5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("perf.freeze_hold", 64'(bubble_cnt), 64'd5);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("perf.saturate", 64'(bubble_cnt), 64'hF);
    checkOutput("perf.flush_zero", 64'(flush_cnt), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("perf.rst_clear", 64'(bubble_cnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
